// File: rtl/axis_demux_1_2.sv
// AXI-Stream 1:2 demultiplexer with packet-atomic routing.
// Each output has a main register plus a one-entry skid register.

module axis_demux_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          skid_full_next
);

    logic          main_v_q, main_v_d;
    logic [DW-1:0] main_data_q, main_data_d;
    logic          main_last_q, main_last_d;
    logic          skid_v_q, skid_v_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          skid_last_q, skid_last_d;
    logic          drain;

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_last_d = main_last_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        drain       = main_v_q & m_tready;

        // The top holds s_tready low whenever a skid is full, so no new
        // beat can arrive while the skid is occupied.
        if (skid_v_q) begin
            if (drain) begin
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                main_last_d = skid_last_q;
                skid_v_d    = 1'b0;
            end
        end else if (in_valid) begin
            if (!main_v_q || drain) begin
                main_v_d    = 1'b1;
                main_data_d = in_data;
                main_last_d = in_last;
            end else begin
                skid_v_d    = 1'b1;
                skid_data_d = in_data;
                skid_last_d = in_last;
            end
        end else if (drain) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_last_q <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_last_q <= main_last_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
        end
    end

    assign m_tdata        = main_data_q;
    assign m_tvalid       = main_v_q;
    assign m_tlast        = main_last_q;
    assign skid_full_next = skid_v_d;

endmodule

// state | meaning
// IDLE  | no packet in progress; next accepted beat is routed by sel
// BUSY  | packet in progress; beats routed by dest_q, sel ignored
module axis_demux_1_2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m1_tdata,
    output logic          m1_tvalid,
    output logic          m1_tlast,
    input  logic          m1_tready,
    output logic [DW-1:0] m2_tdata,
    output logic          m2_tvalid,
    output logic          m2_tlast,
    input  logic          m2_tready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   dest_q, dest_d;
    logic   s_tready_q, s_tready_d;
    logic   accept;
    logic   route;
    logic   to_m1, to_m2;
    logic   skid1_full_next, skid2_full_next;

    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        accept  = s_tvalid & s_tready_q;
        route   = (state_q == IDLE) ? sel : dest_q;
        to_m1   = accept & route;
        to_m2   = accept & ~route;

        if (accept) begin
            if (state_q == IDLE) begin
                dest_d = sel;
            end
            state_d = s_tlast ? IDLE : BUSY;
        end

        s_tready_d = ~skid1_full_next & ~skid2_full_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            dest_q     <= 1'b0;
            s_tready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            s_tready_q <= s_tready_d;
        end
    end

    assign s_tready = s_tready_q;

    axis_demux_slice #(.DW(DW)) u_slice_m1 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (to_m1),
        .in_data        (s_tdata),
        .in_last        (s_tlast),
        .m_tdata        (m1_tdata),
        .m_tvalid       (m1_tvalid),
        .m_tlast        (m1_tlast),
        .m_tready       (m1_tready),
        .skid_full_next (skid1_full_next)
    );

    axis_demux_slice #(.DW(DW)) u_slice_m2 (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (to_m2),
        .in_data        (s_tdata),
        .in_last        (s_tlast),
        .m_tdata        (m2_tdata),
        .m_tvalid       (m2_tvalid),
        .m_tlast        (m2_tlast),
        .m_tready       (m2_tready),
        .skid_full_next (skid2_full_next)
    );

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Randomized and directed bench for axis_demux_1_2 against a queue-based
// model: each output holds the beats accepted for it but not yet delivered.

module tb_axis_demux_1_2;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          sel;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m1_tdata;
    logic          m1_tvalid;
    logic          m1_tlast;
    logic          m1_tready;
    logic [DW-1:0] m2_tdata;
    logic          m2_tvalid;
    logic          m2_tlast;
    logic          m2_tready;

    axis_demux_1_2 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m1_tdata  (m1_tdata),
        .m1_tvalid (m1_tvalid),
        .m1_tlast  (m1_tlast),
        .m1_tready (m1_tready),
        .m2_tdata  (m2_tdata),
        .m2_tvalid (m2_tvalid),
        .m2_tlast  (m2_tlast),
        .m2_tready (m2_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t q1[$];
    beat_t q2[$];
    logic  in_pkt;
    logic  cur_dest;
    logic  rst_prev;
    int    n_vec;
    int    n_err;
    int    m1_beats;
    int    m2_beats;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a beat is buffered until delivered; at most two per output
    // (main + skid), and the input stalls whenever either output holds two.
    always @(negedge clk) begin
        beat_t b;
        logic  dst;
        if (!rst_prev) begin
            chk("rst_s_tready", s_tready, 0);
            chk("rst_m1_tvalid", m1_tvalid, 0);
            chk("rst_m2_tvalid", m2_tvalid, 0);
            chk("rst_m1_tlast", m1_tlast, 0);
            chk("rst_m2_tlast", m2_tlast, 0);
            chk("rst_m1_tdata", m1_tdata, 0);
            chk("rst_m2_tdata", m2_tdata, 0);
            q1.delete();
            q2.delete();
            in_pkt   = 1'b0;
            cur_dest = 1'b0;
        end else begin
            chk("s_tready", s_tready, (q1.size() < 2) && (q2.size() < 2));
            chk("m1_tvalid", m1_tvalid, q1.size() != 0);
            chk("m2_tvalid", m2_tvalid, q2.size() != 0);
            if (q1.size() != 0 && m1_tvalid) begin
                chk("m1_tdata", m1_tdata, q1[0].d);
                chk("m1_tlast", m1_tlast, q1[0].l);
            end
            if (q2.size() != 0 && m2_tvalid) begin
                chk("m2_tdata", m2_tdata, q2[0].d);
                chk("m2_tlast", m2_tlast, q2[0].l);
            end
            if (rst) begin
                if (m1_tvalid && m1_tready && q1.size() != 0) begin
                    void'(q1.pop_front());
                    m1_beats++;
                end
                if (m2_tvalid && m2_tready && q2.size() != 0) begin
                    void'(q2.pop_front());
                    m2_beats++;
                end
                if (s_tvalid && s_tready) begin
                    dst = in_pkt ? cur_dest : sel;
                    b.d = s_tdata;
                    b.l = s_tlast;
                    if (dst) q1.push_back(b);
                    else     q2.push_back(b);
                    cur_dest = dst;
                    in_pkt   = !s_tlast;
                end
            end
        end
        rst_prev = rst;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic sl, input logic [DW-1:0] d, input logic l);
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        sel      = sl;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = s_tready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        s_tvalid = 1'b0;
    endtask

    initial begin
        int m1_before;
        int m2_before;
        n_vec = 0; n_err = 0; m1_beats = 0; m2_beats = 0;
        in_pkt = 1'b0; cur_dest = 1'b0; rst_prev = 1'b0;
        rst = 1'b0; sel = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m1_tready = 1'b1; m2_tready = 1'b1;

        // Reset release
        idle(3);
        rst = 1'b1;
        idle(2);
        chk("ready_after_release", s_tready, 1);

        // 3-beat packet to m1
        m1_before = m1_beats; m2_before = m2_beats;
        send(1, 8'h11, 0);
        send(1, 8'h22, 0);
        send(1, 8'h33, 1);
        idle(3);
        chk("pkt3_m1_count", m1_beats - m1_before, 3);
        chk("pkt3_m2_count", m2_beats - m2_before, 0);

        // sel toggles mid-packet: packet stays on m1, next packet to m2
        m1_before = m1_beats; m2_before = m2_beats;
        send(1, 8'h41, 0);
        send(0, 8'h42, 0);
        send(0, 8'h43, 0);
        send(0, 8'h44, 1);
        send(0, 8'h51, 0);
        send(0, 8'h52, 1);
        idle(3);
        chk("toggle_m1_count", m1_beats - m1_before, 4);
        chk("toggle_m2_count", m2_beats - m2_before, 2);

        // m1 stalled: main + skid fill, input stalls
        m1_tready = 1'b0;
        send(1, 8'h61, 0);
        send(1, 8'h62, 1);
        idle(2);
        chk("stall_s_tready", s_tready, 0);
        m1_before = m1_beats;
        m1_tready = 1'b1;
        idle(3);
        chk("stall_drain_count", m1_beats - m1_before, 2);
        chk("stall_ready_back", s_tready, 1);

        // m2 stalled holding one beat while m1 drains
        m2_tready = 1'b0;
        send(0, 8'h5A, 1);
        m1_before = m1_beats;
        send(1, 8'h71, 0);
        send(1, 8'h72, 0);
        send(1, 8'h73, 1);
        idle(3);
        chk("indep_m1_count", m1_beats - m1_before, 3);
        chk("indep_m2_held", m2_tdata, 8'h5A);
        m2_tready = 1'b1;
        idle(2);

        // Reset mid-packet with beats buffered
        m1_tready = 1'b0;
        send(1, 8'h81, 0);
        send(1, 8'h82, 0);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        m1_tready = 1'b1;
        m1_before = m1_beats; m2_before = m2_beats;
        send(0, 8'hA5, 1);
        idle(3);
        chk("post_rst_m1_count", m1_beats - m1_before, 0);
        chk("post_rst_m2_count", m2_beats - m2_before, 1);

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    send(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
            end
            begin
                for (int i = 0; i < 1200; i++) begin
                    @(posedge clk);
                    #1;
                    m1_tready = $urandom_range(0, 3) != 0;
                    m2_tready = $urandom_range(0, 2) != 0;
                end
            end
        join
        m1_tready = 1'b1;
        m2_tready = 1'b1;
        idle(5);
        chk("final_q1_empty", q1.size(), 0);
        chk("final_q2_empty", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_demux_1_2.md
AXIS_DEMUX_1_2 -- requirements
Module: axis_demux_1_2

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the tdata width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port sel, input, 1 bit: destination select, 1 = m1, 0 = m2.
REQ-005 The block SHALL have ports s_tdata (input, DW), s_tvalid (input, 1), s_tlast (input, 1) and s_tready (output, 1), forming the AXI-Stream slave input.
REQ-006 The block SHALL have ports m1_tdata (output, DW), m1_tvalid (output, 1), m1_tlast (output, 1) and m1_tready (input, 1), forming AXI-Stream master output 1.
REQ-007 The block SHALL have ports m2_tdata (output, DW), m2_tvalid (output, 1), m2_tlast (output, 1) and m2_tready (input, 1), forming AXI-Stream master output 2.

Function
REQ-008 An input beat SHALL be accepted only in a cycle with s_tvalid=1 and s_tready=1.
REQ-009 Routing SHALL be packet-atomic, using a two-state FSM:
- IDLE: no packet is in progress.
- BUSY: a packet is in progress, with its destination latched in dest_q.
REQ-010 A beat accepted in IDLE SHALL be routed by the current sel, and that sel value SHALL be latched into dest_q.
REQ-011 A beat accepted in BUSY SHALL be routed by dest_q; sel SHALL be ignored.
REQ-012 FSM transitions on an accepted beat SHALL be:
- tlast=1 -> IDLE (this covers a single-beat packet in IDLE, which stays IDLE).
- tlast=0 -> BUSY.
REQ-013 The FSM SHALL NOT change state in a cycle with no accepted beat.
REQ-014 Each output SHALL have a register slice made of a main register (drives mX_*) and one skid register.
REQ-015 The block SHALL assert mX_tvalid exactly 1 cycle after the accepting edge of a beat routed to output X, provided mX's main register is free or drains in the accepting cycle.
REQ-016 A beat routed to X while mX_tvalid=1 and mX_tready=0 SHALL be stored in X's skid register.
REQ-017 When mX_tvalid=1, mX_tready=1 and X's skid register is full, the skid contents SHALL move into the main register and the skid SHALL empty.
REQ-018 s_tready SHALL be a register output equal to 1 only when both skid registers are empty (next-state value); s_tready SHALL NOT depend combinationally on sel, s_tvalid or mX_tready.
REQ-019 While mX_tvalid=1 and mX_tready=0, mX_tdata, mX_tlast and mX_tvalid SHALL hold stable.
REQ-020 tdata and tlast SHALL pass through unmodified, and beat order SHALL be preserved per output.
REQ-021 Beats SHALL be neither duplicated nor dropped; a beat goes to exactly one output.
REQ-022 The two outputs SHALL run independently, so a stalled m2 does not stop m1 from draining.
REQ-023 With the destination's mX_tready held at 1 and s_tvalid held at 1, the block SHALL sustain 1 beat per cycle.

Reset
REQ-024 While rst=0, the block SHALL force:
- s_tready=0;
- m1_tvalid=0, m2_tvalid=0;
- m1_tlast=0, m2_tlast=0;
- m1_tdata=0, m2_tdata=0;
- both skid registers empty;
- the FSM to IDLE and dest_q=0.
REQ-025 s_tready SHALL rise at the first rising edge sampling rst=1, so it is 1 one cycle after release.
REQ-026 A reset mid-packet SHALL discard all buffered beats and the partial packet; no closing tlast is generated, and the next accepted beat is treated as a packet start.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset release, outputs idle: s_tready=0 during reset, then 1 the next cycle; all mX_tvalid=0.
- sel=1, 3-beat packet 0x11,0x22,0x33 (tlast on 0x33), m1_tready=1: m1 emits the same data on 3 consecutive cycles, each 1 cycle after acceptance; tlast only on 0x33; m2_tvalid stays 0.
- sel toggles 1->0 after beat 1 of a 4-beat packet: all 4 beats appear on m1; the following packet with sel=0 goes to m2.
- m1_tready=0 while 2 beats are sent to m1: beat 1 holds in main, beat 2 in skid, s_tready=0; after m1_tready=1, the beats exit in order on 2 consecutive cycles and s_tready returns to 1.
- m2 stalled with 1 beat held, then a packet sent to m1 with m1_tready=1: m1 drains normally, and m2 data stays stable throughout.
- rst=0 asserted after beat 2 of a 5-beat packet: outputs clear; after release a 1-beat packet with sel=0, data 0xA5, tlast=1, appears on m2 only.
